// File: rtl/ramtest_pkg.sv
// Shared state encoding, widths and parameter defaults for the RAM tester sequencer.
package ramtest_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_HALT = 4'd1,
        S_PULSE_F   = 4'd2,
        S_START_F   = 4'd3,
        S_RUN_F     = 4'd4,
        S_PULSE_S   = 4'd5,
        S_START_S   = 4'd6,
        S_RUN_S     = 4'd7,
        S_REPORT    = 4'd8
    } state_t;

    localparam int unsigned PULSE_LEN_DEF = 8;
    localparam int unsigned TIMEOUT_DEF   = 32'd268435456;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned TIMER_W       = 32;
    localparam int unsigned PULSE_W       = 8;

    // Phases guarded by the timeout timer.
    function automatic logic is_timed(input state_t s);
        return (s == S_START_F) || (s == S_RUN_F) || (s == S_START_S) || (s == S_RUN_S);
    endfunction

    function automatic logic is_pulse(input state_t s);
        return (s == S_PULSE_F) || (s == S_PULSE_S);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import ramtest_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ramtest_sequencer.sv
// Drives a RAM tester through a fast pass then a slow pass, with timeout,
// bus-hold and abort handling, and keeps pass/fail statistics.
module ramtest_sequencer
    import ramtest_pkg::*;
#(
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        loop_en,
    input  logic        abort,
    input  logic        pause,
    input  logic        test_in_progress,
    input  logic        test_result,
    output logic        hold,
    output logic        rstf,
    output logic        rsts,
    output logic        busy,
    output logic        fast_ok,
    output logic        slow_ok,
    output logic        timeout,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count
);

    state_t               state;
    state_t               state_next;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [TIMER_W-1:0]   phase_timer;
    logic                 abort_pend;

    logic pulse_done_c;
    logic phase_done_c;
    logic timer_exp_c;
    logic start_ok_c;
    logic fast_ld_c;
    logic slow_ld_c;
    logic tmo_fire_c;
    logic pass_inc_c;
    logic fail_inc_c;

    // START_* waits for the tester to go busy, RUN_* waits for it to finish.
    assign pulse_done_c = !pause && (pulse_cnt == PULSE_W'(PULSE_LEN - 1));
    assign phase_done_c = ((state == S_START_F) || (state == S_START_S)) ? test_in_progress
                                                                          : !test_in_progress;
    assign timer_exp_c  = (phase_timer >= TIMER_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_next = S_WAIT_HALT;
            end
            S_WAIT_HALT: begin
                if (abort)                  state_next = S_IDLE;
                else if (!test_in_progress) state_next = S_PULSE_F;
            end
            S_PULSE_F: begin
                if (pulse_done_c) state_next = (abort || abort_pend) ? S_IDLE : S_START_F;
            end
            S_PULSE_S: begin
                if (pulse_done_c) state_next = (abort || abort_pend) ? S_IDLE : S_START_S;
            end
            S_START_F, S_RUN_F, S_START_S, S_RUN_S: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (!pause && phase_done_c) begin
                    case (state)
                        S_START_F: state_next = S_RUN_F;
                        S_RUN_F:   state_next = S_PULSE_S;
                        S_START_S: state_next = S_RUN_S;
                        default:   state_next = S_REPORT;
                    endcase
                end else if (!pause && timer_exp_c) begin
                    state_next = S_IDLE;
                end
            end
            S_REPORT: begin
                state_next = (loop_en && !abort) ? S_WAIT_HALT : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_ok_c = 1'b0;
        fast_ld_c  = 1'b0;
        slow_ld_c  = 1'b0;
        tmo_fire_c = 1'b0;
        pass_inc_c = 1'b0;
        fail_inc_c = 1'b0;
        case (state)
            S_IDLE:   start_ok_c = start && !abort;
            S_RUN_F:  fast_ld_c  = !abort && !pause && phase_done_c;
            S_RUN_S:  slow_ld_c  = !abort && !pause && phase_done_c;
            S_REPORT: begin
                pass_inc_c = fast_ok && slow_ok;
                fail_inc_c = !(fast_ok && slow_ok);
            end
            default: ;
        endcase
        if (is_timed(state) && !abort && !pause && !phase_done_c && timer_exp_c) begin
            tmo_fire_c = 1'b1;
            fail_inc_c = 1'b1;
        end
    end

    // Registered outputs and phase bookkeeping; pulses follow the next state so rstf/rsts align with PULSE_*.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold        <= 1'b0;
            rstf        <= 1'b0;
            rsts        <= 1'b0;
            busy        <= 1'b0;
            fast_ok     <= 1'b0;
            slow_ok     <= 1'b0;
            timeout     <= 1'b0;
            pulse_cnt   <= '0;
            phase_timer <= '0;
            abort_pend  <= 1'b0;
        end else begin
            hold <= pause;
            rstf <= (state_next == S_PULSE_F);
            rsts <= (state_next == S_PULSE_S);
            busy <= (state_next != S_IDLE);

            if (state_next != state) begin
                pulse_cnt   <= '0;
                phase_timer <= '0;
            end else if (!pause) begin
                if (is_pulse(state)) pulse_cnt   <= pulse_cnt + PULSE_W'(1);
                if (is_timed(state)) phase_timer <= phase_timer + TIMER_W'(1);
            end

            if (state_next != state)            abort_pend <= 1'b0;
            else if (is_pulse(state) && abort) abort_pend <= 1'b1;

            if (fast_ld_c) fast_ok <= test_result;
            if (slow_ld_c) slow_ok <= test_result;

            if (tmo_fire_c) begin
                timeout <= 1'b1;
                fast_ok <= 1'b0;
                slow_ok <= 1'b0;
            end else if (start_ok_c) begin
                timeout <= 1'b0;
            end
        end
    end

    sat_counter16 u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pass_inc_c),
        .count (pass_count)
    );

    sat_counter16 u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (fail_inc_c),
        .count (fail_count)
    );

endmodule

// File: tb/tb_ramtest_sequencer.sv
// Scoreboard bench for ramtest_sequencer against a behavioural RAM tester.
module tb_ramtest_sequencer;

    typedef struct packed {
        logic        fast;
        logic        slow;
        logic [15:0] pc;
        logic [15:0] fc;
        logic        to;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        loop_en;
    logic        abort;
    logic        pause;
    logic        test_in_progress;
    logic        test_result;
    logic        hold;
    logic        rstf;
    logic        rsts;
    logic        busy;
    logic        fast_ok;
    logic        slow_ok;
    logic        timeout;
    logic [15:0] pass_count;
    logic [15:0] fail_count;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [15:0] exp_pass = 16'd0;
    logic [15:0] exp_fail = 16'd0;

    // Tester model configuration.
    logic tester_en   = 1'b0;
    logic tester_busy = 1'b1;
    logic fast_res    = 1'b1;
    logic slow_res    = 1'b1;
    int   fast_len    = 15;
    int   slow_len    = 20;
    logic prev_f      = 1'b0;
    logic prev_s      = 1'b0;
    logic is_fast     = 1'b0;

    ramtest_sequencer #(
        .PULSE_LEN (8),
        .TIMEOUT   (1000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .loop_en          (loop_en),
        .abort            (abort),
        .pause            (pause),
        .test_in_progress (test_in_progress),
        .test_result      (test_result),
        .hold             (hold),
        .rstf             (rstf),
        .rsts             (rsts),
        .busy             (busy),
        .fast_ok          (fast_ok),
        .slow_ok          (slow_ok),
        .timeout          (timeout),
        .pass_count       (pass_count),
        .fail_count       (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tester: power-up self-run, then a run after the falling edge of each start pulse.
    initial begin
        test_in_progress = 1'b1;
        test_result      = 1'b0;
        repeat (30) @(negedge clk);
        test_in_progress = 1'b0;
        tester_busy      = 1'b0;
        forever begin
            @(negedge clk);
            if (tester_en && ((prev_f && !rstf) || (prev_s && !rsts))) begin
                is_fast     = prev_f;
                tester_busy = 1'b1;
                repeat (3) @(negedge clk);
                test_in_progress = 1'b1;
                repeat (is_fast ? fast_len : slow_len) @(negedge clk);
                test_result      = is_fast ? fast_res : slow_res;
                test_in_progress = 1'b0;
                tester_busy      = 1'b0;
            end
            prev_f = rstf;
            prev_s = rsts;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic issue_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_tester_idle();
        for (int i = 0; i < 3000 && tester_busy; i++) @(negedge clk);
    endtask

    // Observes one sequence until busy drops; measures pulse widths and post-pulse busy cycles.
    task automatic run_pair(output int rf_len, output int rs_len, output int overlap,
                            output int tail, output bit done);
        bit seen_f;
        seen_f  = 1'b0;
        rf_len  = 0;
        rs_len  = 0;
        overlap = 0;
        tail    = 0;
        done    = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rstf) begin
                rf_len++;
                seen_f = 1'b1;
            end
            if (rsts) rs_len++;
            if (rstf && rsts) overlap++;
            if (seen_f && busy && !rstf && !rsts) tail++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; loop_en = 1'b0; abort = 1'b0; pause = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hold, rstf, rsts, busy, fast_ok, slow_ok, timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {hold, rstf, rsts, busy, fast_ok, slow_ok, timeout});
        end
        checks++;
        if (pass_count !== 16'd0 || fail_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: got pass=%0d fail=%0d want 0 0", pass_count, fail_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        exp_t e;
        int   rf, rs, ov, tl;
        bit   done;
        tester_en = 1'b1; fast_res = 1'b1; slow_res = 1'b1; fast_len = 15; slow_len = 20;
        exp_pass = exp_pass + 16'd1;
        e = '{fast: 1'b1, slow: 1'b1, pc: exp_pass, fc: exp_fail, to: 1'b0};
        sb.push_back(e);
        issue_start();
        checks++;
        if (busy !== 1'b1 || rstf !== 1'b0) begin
            errors++;
            $display("FAIL pass_wait_halt: got busy=%b rstf=%b want 1 0", busy, rstf);
        end
        run_pair(rf, rs, ov, tl, done);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL pass_done: busy never dropped");
        end
        checks++;
        if (rf != 8 || rs != 8 || ov != 0) begin
            errors++;
            $display("FAIL pass_pulses: got rstf=%0d rsts=%0d overlap=%0d want 8 8 0", rf, rs, ov);
        end
        e = sb.pop_front();
        checks++;
        if ({fast_ok, slow_ok, pass_count, fail_count, timeout} !== e) begin
            errors++;
            $display("FAIL pass_outcome: got %b %b %0d %0d %b want %b %b %0d %0d %b",
                     fast_ok, slow_ok, pass_count, fail_count, timeout,
                     e.fast, e.slow, e.pc, e.fc, e.to);
        end
    endtask

    task automatic test_slow_fail();
        exp_t e;
        int   rf, rs, ov, tl;
        bit   done;
        wait_tester_idle();
        tester_en = 1'b1; fast_res = 1'b1; slow_res = 1'b0;
        exp_fail = exp_fail + 16'd1;
        e = '{fast: 1'b1, slow: 1'b0, pc: exp_pass, fc: exp_fail, to: 1'b0};
        sb.push_back(e);
        issue_start();
        run_pair(rf, rs, ov, tl, done);
        checks++;
        if (done !== 1'b1 || rf != 8 || rs != 8) begin
            errors++;
            $display("FAIL slowfail_seq: got done=%b rstf=%0d rsts=%0d want 1 8 8", done, rf, rs);
        end
        e = sb.pop_front();
        checks++;
        if ({fast_ok, slow_ok, pass_count, fail_count, timeout} !== e) begin
            errors++;
            $display("FAIL slowfail_outcome: got %b %b %0d %0d %b want %b %b %0d %0d %b",
                     fast_ok, slow_ok, pass_count, fail_count, timeout,
                     e.fast, e.slow, e.pc, e.fc, e.to);
        end
        slow_res = 1'b1;
    endtask

    task automatic test_timeout();
        exp_t e;
        int   rf, rs, ov, tl;
        bit   done;
        wait_tester_idle();
        tester_en = 1'b0;
        exp_fail = exp_fail + 16'd1;
        e = '{fast: 1'b0, slow: 1'b0, pc: exp_pass, fc: exp_fail, to: 1'b1};
        sb.push_back(e);
        issue_start();
        run_pair(rf, rs, ov, tl, done);
        checks++;
        if (done !== 1'b1 || rf != 8 || rs != 0) begin
            errors++;
            $display("FAIL timeout_seq: got done=%b rstf=%0d rsts=%0d want 1 8 0", done, rf, rs);
        end
        checks++;
        if (tl != 1000) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want 1000", tl);
        end
        e = sb.pop_front();
        checks++;
        if ({fast_ok, slow_ok, pass_count, fail_count, timeout} !== e) begin
            errors++;
            $display("FAIL timeout_outcome: got %b %b %0d %0d %b want %b %b %0d %0d %b",
                     fast_ok, slow_ok, pass_count, fail_count, timeout,
                     e.fast, e.slow, e.pc, e.fc, e.to);
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL start_abort: got busy=%b timeout=%b want 0 1", busy, timeout);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_pause();
        exp_t e;
        int   rf, rs, ov, tl, n;
        bit   done;
        tester_en = 1'b1; fast_len = 1200; slow_len = 20;
        exp_pass = exp_pass + 16'd1;
        e = '{fast: 1'b1, slow: 1'b1, pc: exp_pass, fc: exp_fail, to: 1'b0};
        sb.push_back(e);
        issue_start();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL pause_timeout_clear: got %b want 0", timeout);
        end
        fork
            run_pair(rf, rs, ov, tl, done);
            begin
                n = 0;
                while (!test_in_progress && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10) @(negedge clk);
                pause = 1'b1;
                #1;
                checks++;
                if (hold !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_latency: got %b want 0", hold);
                end
                @(negedge clk);
                checks++;
                if (hold !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_set: got %b want 1", hold);
                end
                repeat (499) @(negedge clk);
                pause = 1'b0;
                @(negedge clk);
                checks++;
                if (hold !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_clear: got %b want 0", hold);
                end
            end
        join
        checks++;
        if (done !== 1'b1 || rs != 8) begin
            errors++;
            $display("FAIL pause_seq: got done=%b rsts=%0d want 1 8", done, rs);
        end
        e = sb.pop_front();
        checks++;
        if ({fast_ok, slow_ok, pass_count, fail_count, timeout} !== e) begin
            errors++;
            $display("FAIL pause_outcome: got %b %b %0d %0d %b want %b %b %0d %0d %b",
                     fast_ok, slow_ok, pass_count, fail_count, timeout,
                     e.fast, e.slow, e.pc, e.fc, e.to);
        end
        fast_len = 15;
    endtask

    task automatic test_loop_abort();
        exp_t        e;
        int          falls;
        logic        ps;
        logic [15:0] last_pc;
        bit          aborted;
        falls = 0; ps = 1'b0; aborted = 1'b0;
        wait_tester_idle();
        tester_en = 1'b1; fast_res = 1'b1; slow_res = 1'b1;
        loop_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_pass = exp_pass + 16'd1;
            e = '{fast: 1'b1, slow: 1'b1, pc: exp_pass, fc: exp_fail, to: 1'b0};
            sb.push_back(e);
        end
        last_pc = pass_count;
        issue_start();
        for (int i = 0; i < 3000 && !aborted; i++) begin
            @(negedge clk);
            if (ps && !rsts) falls++;
            ps = rsts;
            if (pass_count !== last_pc) begin
                last_pc = pass_count;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL loop_extra_pass: got pass=%0d want no further pass", pass_count);
                end else begin
                    e = sb.pop_front();
                    if (pass_count !== e.pc || fail_count !== e.fc) begin
                        errors++;
                        $display("FAIL loop_count: got %0d %0d want %0d %0d",
                                 pass_count, fail_count, e.pc, e.fc);
                    end
                end
            end
            if (falls == 3 && test_in_progress) begin
                repeat (5) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort   = 1'b0;
                loop_en = 1'b0;
                aborted = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL loop_abort_idle: got busy=%b want 0", busy);
                end
            end
        end
        checks++;
        if (!aborted || sb.size() != 0) begin
            errors++;
            $display("FAIL loop_progress: got aborted=%b pending=%0d want 1 0", aborted, sb.size());
        end
        sb.delete();
        checks++;
        if (pass_count !== exp_pass || fail_count !== exp_fail) begin
            errors++;
            $display("FAIL loop_final: got %0d %0d want %0d %0d",
                     pass_count, fail_count, exp_pass, exp_fail);
        end
    endtask

    task automatic test_abort_pulse();
        int rf, rs, ov, tl, n;
        bit done;
        wait_tester_idle();
        tester_en = 1'b0;
        issue_start();
        fork
            run_pair(rf, rs, ov, tl, done);
            begin
                n = 0;
                while (!rstf && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        join
        checks++;
        if (done !== 1'b1 || rf != 8 || rs != 0 || tl != 0) begin
            errors++;
            $display("FAIL abort_pulse: got done=%b rstf=%0d rsts=%0d tail=%0d want 1 8 0 0",
                     done, rf, rs, tl);
        end
        checks++;
        if (pass_count !== exp_pass || fail_count !== exp_fail) begin
            errors++;
            $display("FAIL abort_pulse_counts: got %0d %0d want %0d %0d",
                     pass_count, fail_count, exp_pass, exp_fail);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        tester_en = 1'b0;
        issue_start();
        n = 0;
        while (!rstf && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rstf !== 1'b1) begin
            errors++;
            $display("FAIL midpulse_rstf: got %b want 1", rstf);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({hold, rstf, rsts, busy, fast_ok, slow_ok, timeout} !== 7'b0 ||
            pass_count !== 16'd0 || fail_count !== 16'd0) begin
            errors++;
            $display("FAIL midpulse_reset: got flags=%b pass=%0d fail=%0d want 0 0 0",
                     {hold, rstf, rsts, busy, fast_ok, slow_ok, timeout}, pass_count, fail_count);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pass = 16'd0;
        exp_fail = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rstf !== 1'b0) begin
            errors++;
            $display("FAIL midpulse_idle: got busy=%b rstf=%b want 0 0", busy, rstf);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_slow_fail();
        test_timeout();
        test_start_abort();
        test_pause();
        test_loop_abort();
        test_abort_pulse();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
